// File: rtl/conv_1x1_sched.sv
// conv_1x1_sched
//   Sequencer for the 1x1 convolution datapath. For every output channel it
//   walks all input channels. Per input channel it fetches one weight, pulses
//   load_weights, then streams the whole image plane with a valid/ready
//   handshake, tagging each beat with accumulate-first/last flags.
//
//   Ports:
//     clk, reset      clock (rising edge), synchronous active-high reset
//     start           run request, honoured only while idle
//     busy, done      run in progress / one-cycle end-of-run pulse
//     weight_req/addr weight fetch request, address = oc*CHANNEL_NUM_IN+ic
//     weight_ack      weight delivered this cycle
//     load_weights    one-cycle strobe to the datapath weight buffer
//     pxl_req/addr    pixel beat valid, address = ic*IMAGE_SIZE+pix
//     pxl_rdy         datapath accepts the beat
//     acc_first/last  beat belongs to the first / last input channel
//     oc_idx          current output channel
//
//   Optional build macro CONV_1X1_SCHED_STALL_CNT_EN adds output stall_cnt
//   (32 bits): saturating count of cycles where a request is pending but not
//   taken. Cleared by reset and by an accepted start.
//
//   Channel timing: one LOAD_W cycle (or more while weight_ack is low), one
//   weight-load cycle in which no pixel beat is offered, then IMAGE_SIZE beats.
module conv_1x1_sched #(
   parameter int IMAGE_WIDTH     = 64,
   parameter int IMAGE_HEIGHT    = 64,
   parameter int CHANNEL_NUM_IN  = 256,
   parameter int CHANNEL_NUM_OUT = 256,
   parameter int PXL_ADDR_WIDTH  = 20,
   parameter int W_ADDR_WIDTH    = 16,
   parameter int CH_WIDTH        = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      weight_req,
   output logic [W_ADDR_WIDTH-1:0]   weight_addr,
   input  logic                      weight_ack,
   output logic                      load_weights,
   output logic                      pxl_req,
   output logic [PXL_ADDR_WIDTH-1:0] pxl_addr,
   input  logic                      pxl_rdy,
   output logic                      acc_first,
   output logic                      acc_last,
   output logic [CH_WIDTH-1:0]       oc_idx
`ifdef CONV_1X1_SCHED_STALL_CNT_EN
   ,
   output logic [31:0]               stall_cnt
`endif
);

   localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int PIX_W      = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

   localparam logic [PIX_W-1:0]    PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
   localparam logic [CH_WIDTH-1:0] IC_LAST  = CH_WIDTH'(CHANNEL_NUM_IN - 1);
   localparam logic [CH_WIDTH-1:0] OC_LAST  = CH_WIDTH'(CHANNEL_NUM_OUT - 1);

   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_t;

   state_t              state_reg;
   logic [CH_WIDTH-1:0] ic_reg;
   logic [PIX_W-1:0]    pix_reg;

   // Addresses are kept as running counters instead of being multiplied out:
   // weight_addr advances by one per (oc, ic) pair, and pxl_addr advances by
   // one per beat across the input-channel planes, restarting at each oc.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         ic_reg       <= '0;
         pix_reg      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         weight_req   <= 1'b0;
         weight_addr  <= '0;
         load_weights <= 1'b0;
         pxl_req      <= 1'b0;
         pxl_addr     <= '0;
         acc_first    <= 1'b0;
         acc_last     <= 1'b0;
         oc_idx       <= '0;
      end else begin
         load_weights <= 1'b0;
         done         <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg  <= LOAD_W;
                  busy       <= 1'b1;
                  weight_req <= 1'b1;
               end
            end
            LOAD_W: begin
               if (weight_ack) begin
                  weight_req   <= 1'b0;
                  load_weights <= 1'b1;
                  pix_reg      <= '0;
                  state_reg    <= STREAM;
               end
            end
            STREAM: begin
               if (!pxl_req) begin
                  // Weight-load cycle: the first beat is offered next cycle.
                  pxl_req   <= 1'b1;
                  acc_first <= (ic_reg == '0);
                  acc_last  <= (ic_reg == IC_LAST);
               end else if (pxl_rdy) begin
                  if (pix_reg != PIX_LAST) begin
                     pix_reg  <= pix_reg + PIX_W'(1);
                     pxl_addr <= pxl_addr + PXL_ADDR_WIDTH'(1);
                  end else begin
                     pxl_req   <= 1'b0;
                     acc_first <= 1'b0;
                     acc_last  <= 1'b0;
                     pix_reg   <= '0;
                     if (ic_reg != IC_LAST) begin
                        ic_reg      <= ic_reg + CH_WIDTH'(1);
                        pxl_addr    <= pxl_addr + PXL_ADDR_WIDTH'(1);
                        weight_addr <= weight_addr + W_ADDR_WIDTH'(1);
                        weight_req  <= 1'b1;
                        state_reg   <= LOAD_W;
                     end else if (oc_idx != OC_LAST) begin
                        ic_reg      <= '0;
                        oc_idx      <= oc_idx + CH_WIDTH'(1);
                        pxl_addr    <= '0;
                        weight_addr <= weight_addr + W_ADDR_WIDTH'(1);
                        weight_req  <= 1'b1;
                        state_reg   <= LOAD_W;
                     end else begin
                        ic_reg      <= '0;
                        oc_idx      <= '0;
                        pxl_addr    <= '0;
                        weight_addr <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_reg   <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               // Counters were cleared on entry; start here is ignored.
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef CONV_1X1_SCHED_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (state_reg == IDLE && start) begin
         stall_cnt <= '0;
      end else if (((weight_req & ~weight_ack) | (pxl_req & ~pxl_rdy)) &&
                   (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_1x1_sched.sv
// tb_conv_1x1_sched
//   Self-checking bench for conv_1x1_sched with a 2x2 image, 2 input and
//   2 output channels. A table of run scenarios (weight_ack delay, pxl_rdy
//   pattern, start noise, expected run length) is applied in a loop; each run
//   is checked against a reference transaction list built from the address
//   and flag formulas. Hand-written sequences cover reset state and reset in
//   the middle of a stream.
module tb_conv_1x1_sched;

   localparam int IW   = 2;
   localparam int IH   = 2;
   localparam int CIN  = 2;
   localparam int COUT = 2;
   localparam int IS   = IW * IH;
   localparam int PAW  = 20;
   localparam int WAW  = 16;
   localparam int CHW  = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           busy;
   logic           done;
   logic           weight_req;
   logic [WAW-1:0] weight_addr;
   logic           weight_ack;
   logic           load_weights;
   logic           pxl_req;
   logic [PAW-1:0] pxl_addr;
   logic           pxl_rdy;
   logic           acc_first;
   logic           acc_last;
   logic [CHW-1:0] oc_idx;
`ifdef CONV_1X1_SCHED_STALL_CNT_EN
   logic [31:0]    stall_cnt;
`endif

   conv_1x1_sched #(
      .IMAGE_WIDTH    (IW),
      .IMAGE_HEIGHT   (IH),
      .CHANNEL_NUM_IN (CIN),
      .CHANNEL_NUM_OUT(COUT),
      .PXL_ADDR_WIDTH (PAW),
      .W_ADDR_WIDTH   (WAW),
      .CH_WIDTH       (CHW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .weight_req   (weight_req),
      .weight_addr  (weight_addr),
      .weight_ack   (weight_ack),
      .load_weights (load_weights),
      .pxl_req      (pxl_req),
      .pxl_addr     (pxl_addr),
      .pxl_rdy      (pxl_rdy),
      .acc_first    (acc_first),
      .acc_last     (acc_last),
      .oc_idx       (oc_idx)
`ifdef CONV_1X1_SCHED_STALL_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int addr;
      bit first;
      bit last;
      int oc;
      bit plane_end;
   } beat_t;

   // ack_delay: -1 random ack; rdy_mode: 0 tied high, 1 toggling, 2 random.
   // exp_len: start cycle through done cycle inclusive, -1 when not fixed.
   typedef struct {
      int ack_delay;
      int rdy_mode;
      bit noise;
      int exp_len;
   } case_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_wreq"}, weight_req, 0);
      chk({tag, "_waddr"}, weight_addr, 0);
      chk({tag, "_loadw"}, load_weights, 0);
      chk({tag, "_preq"}, pxl_req, 0);
      chk({tag, "_paddr"}, pxl_addr, 0);
      chk({tag, "_first"}, acc_first, 0);
      chk({tag, "_last"}, acc_last, 0);
      chk({tag, "_oc"}, oc_idx, 0);
   endtask

   task automatic run_case(input int idx, input case_t c);
      int    w_q[$];
      beat_t b_q[$];
      beat_t eb;
      beat_t nb;
      int    cyc, wwait, beats, loads, dones, stalls, exp_w;
      bit    finished, prev_wx, prev_ws, prev_ps, prev_last;
      logic [PAW-1:0] prev_paddr;
      logic [WAW-1:0] prev_waddr;
      logic           prev_f, prev_l;

      // Reference transaction lists straight from the address formulas.
      for (int oc = 0; oc < COUT; oc++)
         for (int ic = 0; ic < CIN; ic++) begin
            w_q.push_back(oc * CIN + ic);
            for (int p = 0; p < IS; p++) begin
               nb.addr = ic * IS + p;
               nb.first = (ic == 0);
               nb.last = (ic == CIN - 1);
               nb.oc = oc;
               nb.plane_end = (p == IS - 1);
               b_q.push_back(nb);
            end
         end

      @(negedge clk);
      chk("idle_before_start", busy, 0);
      start = 1'b1;
      weight_ack = 1'b0;
      pxl_rdy = 1'b0;
      cyc = 0; wwait = 0; beats = 0; loads = 0; dones = 0; stalls = 0;
      finished = 0; prev_wx = 0; prev_ws = 0; prev_ps = 0; prev_last = 0;
      prev_paddr = '0; prev_waddr = '0; prev_f = 0; prev_l = 0;

      while (!finished && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = c.noise ? 1'($urandom_range(0, 1)) : 1'b0;

         chk("no_dual_req", weight_req & pxl_req, 0);
         chk("load_strobe", load_weights, prev_wx);
         if (load_weights) loads++;
         if (prev_ws) begin
            chk("wreq_hold", weight_req, 1);
            chk("waddr_hold", weight_addr, prev_waddr);
         end
         if (prev_ps) begin
            chk("preq_hold", pxl_req, 1);
            chk("paddr_hold", pxl_addr, prev_paddr);
            chk("first_hold", acc_first, prev_f);
            chk("last_hold", acc_last, prev_l);
         end
         if (prev_last) chk("preq_drop", pxl_req, 0);
         if (done) begin
            dones++;
            chk("busy_in_done", busy, 0);
            finished = 1;
            if (c.noise) start = 1'b1;
         end else begin
            chk("busy_in_run", busy, 1);
         end

         // Drive handshake inputs for this cycle.
         if (weight_req) wwait++;
         if (c.ack_delay < 0) weight_ack = 1'($urandom_range(0, 1));
         else weight_ack = weight_req && (wwait > c.ack_delay);
         case (c.rdy_mode)
            0:       pxl_rdy = 1'b1;
            1:       pxl_rdy = cyc[0];
            default: pxl_rdy = 1'($urandom_range(0, 1));
         endcase
         if ((weight_req && !weight_ack) || (pxl_req && !pxl_rdy)) stalls++;

         prev_last = 0;
         if (weight_req && weight_ack) begin
            wwait = 0;
            if (w_q.size() == 0) begin
               chk("extra_fetch", 1, 0);
            end else begin
               exp_w = w_q.pop_front();
               chk("weight_addr", weight_addr, exp_w);
               $display("run %0d fetch weight_addr=%0d", idx, weight_addr);
            end
         end
         if (pxl_req && pxl_rdy) begin
            beats++;
            if (b_q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               eb = b_q.pop_front();
               chk("pxl_addr", pxl_addr, eb.addr);
               chk("acc_first", acc_first, eb.first);
               chk("acc_last", acc_last, eb.last);
               chk("oc_idx", oc_idx, eb.oc);
               prev_last = eb.plane_end;
               $display("run %0d beat pxl_addr=%0d first=%0d last=%0d oc=%0d",
                        idx, pxl_addr, acc_first, acc_last, oc_idx);
            end
         end
         prev_wx = weight_req && weight_ack;
         prev_ws = weight_req && !weight_ack;
         prev_ps = pxl_req && !pxl_rdy;
         prev_waddr = weight_addr;
         prev_paddr = pxl_addr;
         prev_f = acc_first;
         prev_l = acc_last;
      end

      chk("run_finished", finished, 1);
      chk("beat_count", beats, COUT * CIN * IS);
      chk("load_count", loads, COUT * CIN);
      chk("fetches_left", w_q.size(), 0);
      chk("beats_left", b_q.size(), 0);
      if (c.exp_len >= 0) chk("run_length", cyc + 1, c.exp_len);

      // Cycle after DONE: a start during DONE must not have restarted a run.
      @(negedge clk);
      start = 1'b0;
      weight_ack = 1'b0;
      pxl_rdy = 1'b0;
      chk("idle_busy_after", busy, 0);
      chk("idle_wreq_after", weight_req, 0);
      chk("done_single", done, 0);
`ifdef CONV_1X1_SCHED_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stalls);
`endif
      @(negedge clk);
      chk("still_idle", busy, 0);
      $display("run %0d complete: cycles=%0d beats=%0d loads=%0d dones=%0d stalls=%0d",
               idx, cyc + 1, beats, loads, dones, stalls);
   endtask

   case_t cases[6];
   bit    found;

   initial begin
      cases[0] = '{ack_delay: 0,  rdy_mode: 0, noise: 1'b0, exp_len: COUT*CIN*(IS+2)+2};
      cases[1] = '{ack_delay: 3,  rdy_mode: 0, noise: 1'b0, exp_len: COUT*CIN*(IS+2)+2+COUT*CIN*3};
      cases[2] = '{ack_delay: 0,  rdy_mode: 1, noise: 1'b0, exp_len: -1};
      cases[3] = '{ack_delay: 0,  rdy_mode: 0, noise: 1'b1, exp_len: COUT*CIN*(IS+2)+2};
      cases[4] = '{ack_delay: -1, rdy_mode: 2, noise: 1'b1, exp_len: -1};
      cases[5] = '{ack_delay: -1, rdy_mode: 2, noise: 1'b0, exp_len: -1};

      reset = 1'b1;
      start = 1'b0;
      weight_ack = 1'b0;
      pxl_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
`ifdef CONV_1X1_SCHED_STALL_CNT_EN
      chk("reset_stall", stall_cnt, 0);
`endif
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_case(i, cases[i]);

      // Reset in the middle of STREAM at oc=1, ic=0, pix=2.
      @(negedge clk);
      start = 1'b1;
      weight_ack = 1'b1;
      pxl_rdy = 1'b1;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (pxl_req && oc_idx == 1 && pxl_addr == 2) found = 1;
      end
      chk("reset_target_found", found, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      weight_ack = 1'b0;
      pxl_rdy = 1'b0;
      chk_all_zero("midreset");
      $display("mid-stream reset applied");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("no_done_after_reset", done, 0);
         chk("no_busy_after_reset", busy, 0);
      end

      // Fresh run after the reset replays from weight_addr 0.
      run_case(6, cases[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
